// File: rtl/bsg_clk_mon_scan.sv
// Multi-channel divided-clock edge counter with windowed measurement, scan mode and sticky limit faults.
// Latency en_i -> v_o is sync_stages_p+1+W+1 cycles; a held result (v_o without yumi_i) stalls further windows.
module bsg_clk_mon_scan #(
  parameter int num_ch_p       = 4,
  parameter int count_width_p  = 16,
  parameter int window_width_p = 16,
  parameter int sync_stages_p  = 2,
  localparam int ch_w_lp       = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      async_reset_ni,
  input  logic                      en_i,
  input  logic                      scan_i,
  input  logic [ch_w_lp-1:0]        sel_i,
  input  logic [window_width_p-1:0] window_i,
  input  logic [count_width_p-1:0]  lo_thresh_i,
  input  logic [count_width_p-1:0]  hi_thresh_i,
  input  logic                      clear_i,
  input  logic [num_ch_p-1:0]       div_clk_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [count_width_p-1:0]  count_o,
  output logic [ch_w_lp-1:0]        ch_o,
  output logic                      sat_o,
  output logic [num_ch_p-1:0]       fault_o
);

  localparam int set_w_lp = $clog2(sync_stages_p + 2);
  localparam int tmr_w_lp = (window_width_p > set_w_lp) ? window_width_p : set_w_lp;

  typedef enum logic [1:0] {s_idle, s_settle, s_measure, s_hold} state_e;

  state_e                                     state_r, state_n;
  logic [sync_stages_p-1:0][num_ch_p-1:0]     sync_r;
  logic [num_ch_p-1:0]                        prev_r, rise_w;
  logic [tmr_w_lp-1:0]                        tmr_r, tmr_n, win_r, win_n;
  logic [count_width_p-1:0]                   cnt_r, cnt_n;
  logic                                       sat_r, sat_n;
  logic [ch_w_lp-1:0]                         ch_r, ch_n, ptr_r, ptr_n, ch_adv_w, ch_pick_w;
  logic [num_ch_p-1:0]                        fault_r, fault_set;
  logic [window_width_p-1:0]                  win_m1_w;

  // Edge detector runs every cycle, so prev already tracks synced when SETTLE ends.
  always_ff @(posedge clk_i or negedge async_reset_ni) begin
    if (!async_reset_ni) begin
      sync_r <= '0;
      prev_r <= '0;
    end else begin
      sync_r <= {sync_r[sync_stages_p-2:0], div_clk_i};
      prev_r <= sync_r[sync_stages_p-1];
    end
  end

  assign rise_w   = sync_r[sync_stages_p-1] & ~prev_r;
  assign ch_adv_w = (ch_r == ch_w_lp'(num_ch_p - 1)) ? '0 : ch_r + ch_w_lp'(1);
  assign win_m1_w = (window_i == '0) ? '0 : window_i - window_width_p'(1);

  always_comb begin
    state_n   = state_r;
    tmr_n     = tmr_r;
    win_n     = win_r;
    cnt_n     = cnt_r;
    sat_n     = sat_r;
    ch_n      = ch_r;
    ptr_n     = ptr_r;
    fault_set = '0;
    if (state_r == s_hold && yumi_i && scan_i) ptr_n = ch_adv_w;
    ch_pick_w = (num_ch_p == 1) ? '0 : (scan_i ? ptr_n : sel_i);

    unique case (state_r)
      s_idle: begin
        if (en_i) begin
          state_n = s_settle;
          tmr_n   = tmr_w_lp'(sync_stages_p);
          ch_n    = ch_pick_w;
          win_n   = tmr_w_lp'(win_m1_w);
        end
      end
      s_settle: begin
        if (!en_i) begin
          state_n = s_idle;
        end else if (tmr_r == '0) begin
          state_n = s_measure;
          tmr_n   = win_r;
          cnt_n   = '0;
          sat_n   = 1'b0;
        end else begin
          tmr_n = tmr_r - tmr_w_lp'(1);
        end
      end
      s_measure: begin
        if (!en_i) begin
          state_n = s_idle;
        end else begin
          if (rise_w[ch_r]) begin
            if (&cnt_r) sat_n = 1'b1;
            else        cnt_n = cnt_r + count_width_p'(1);
          end
          if (tmr_r == '0) begin
            state_n = s_hold;
            if (cnt_n < lo_thresh_i || cnt_n > hi_thresh_i) fault_set[ch_r] = 1'b1;
          end else begin
            tmr_n = tmr_r - tmr_w_lp'(1);
          end
        end
      end
      s_hold: begin
        if (yumi_i) begin
          if (en_i) begin
            state_n = s_settle;
            tmr_n   = tmr_w_lp'(sync_stages_p);
            ch_n    = ch_pick_w;
            win_n   = tmr_w_lp'(win_m1_w);
          end else begin
            state_n = s_idle;
          end
        end
      end
      default: state_n = s_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_reset_ni) begin
    if (!async_reset_ni) begin
      state_r <= s_idle;
      tmr_r   <= '0;
      win_r   <= '0;
      cnt_r   <= '0;
      sat_r   <= 1'b0;
      ch_r    <= '0;
      ptr_r   <= '0;
      fault_r <= '0;
    end else begin
      state_r <= state_n;
      tmr_r   <= tmr_n;
      win_r   <= win_n;
      cnt_r   <= cnt_n;
      sat_r   <= sat_n;
      ch_r    <= ch_n;
      ptr_r   <= ptr_n;
      // A new fault wins over a simultaneous clear for the same bit.
      fault_r <= (clear_i ? '0 : fault_r) | fault_set;
    end
  end

  assign v_o     = (state_r == s_hold);
  assign count_o = cnt_r;
  assign ch_o    = ch_r;
  assign sat_o   = sat_r;
  assign fault_o = fault_r;

endmodule

// File: tb/tb_bsg_clk_mon_scan.sv
// Directed bench for bsg_clk_mon_scan: a 16-bit-count instance plus a 4-bit-count instance for saturation.
module tb_bsg_clk_mon_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, en4 = 1'b0, scan = 1'b0, clear = 1'b0;
  logic        yumi = 1'b0, yumi4 = 1'b0;
  logic [1:0]  sel = '0;
  logic [15:0] window = '0, lo = '0, hi = '0;
  logic [3:0]  div_clk = '0;
  logic        v, sat, v4, sat4;
  logic [15:0] count;
  logic [3:0]  count4, fault, fault4;
  logic [1:0]  ch, ch4;

  int total = 0, bad = 0;
  int cyc = 0;
  int per [4] = '{4, 8, 10, 32};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    for (int i = 0; i < 4; i++) div_clk[i] <= ((cyc % per[i]) < (per[i] / 2));

  bsg_clk_mon_scan dut (
    .clk_i(clk), .async_reset_ni(rst_n), .en_i(en), .scan_i(scan), .sel_i(sel),
    .window_i(window), .lo_thresh_i(lo), .hi_thresh_i(hi), .clear_i(clear),
    .div_clk_i(div_clk), .v_o(v), .yumi_i(yumi), .count_o(count), .ch_o(ch),
    .sat_o(sat), .fault_o(fault)
  );

  bsg_clk_mon_scan #(.count_width_p(4)) dut4 (
    .clk_i(clk), .async_reset_ni(rst_n), .en_i(en4), .scan_i(scan), .sel_i(sel),
    .window_i(window), .lo_thresh_i(lo[3:0]), .hi_thresh_i(hi[3:0]), .clear_i(clear),
    .div_clk_i(div_clk), .v_o(v4), .yumi_i(yumi4), .count_o(count4), .ch_o(ch4),
    .sat_o(sat4), .fault_o(fault4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v(input int maxc, output int n);
    n = 0;
    while (v !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic consume(input logic keep_en);
    en = keep_en;
    yumi = 1'b1;
    step();
    yumi = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total++; if (v !== 1'b0)      begin bad++; $display("FAIL rst_v: got %b want 0", v); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if (ch !== 2'd0)     begin bad++; $display("FAIL rst_ch: got %0d want 0", ch); end
    total++; if (sat !== 1'b0)    begin bad++; $display("FAIL rst_sat: got %b want 0", sat); end
    total++; if (fault !== 4'd0)  begin bad++; $display("FAIL rst_fault: got %b want 0000", fault); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n;
    per = '{4, 8, 10, 32};
    sel = 2'd2; scan = 1'b0; window = 16'd100; lo = 16'd0; hi = 16'd100;
    repeat (2) step();
    en = 1'b1;
    wait_v(300, n);
    total++; if (n != 104)        begin bad++; $display("FAIL single_lat: got %0d want 104", n); end
    total++; if (count !== 16'd10) begin bad++; $display("FAIL single_count: got %0d want 10", count); end
    total++; if (ch !== 2'd2)     begin bad++; $display("FAIL single_ch: got %0d want 2", ch); end
    total++; if (sat !== 1'b0)    begin bad++; $display("FAIL single_sat: got %b want 0", sat); end
    total++; if (fault !== 4'd0)  begin bad++; $display("FAIL single_fault: got %b want 0000", fault); end
    consume(1'b0);
    total++; if (v !== 1'b0)      begin bad++; $display("FAIL single_v_drop: got %b want 0", v); end
  endtask

  task automatic test_scan();
    int n;
    logic [1:0]  exp_ch  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_cnt [5] = '{16'd16, 16'd8, 16'd4, 16'd2, 16'd16};
    per = '{4, 8, 16, 32};
    window = 16'd64; lo = 16'd3; hi = 16'd12; scan = 1'b1;
    clear = 1'b1; step(); clear = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_v(300, n);
      total++; if (v !== 1'b1) begin bad++; $display("FAIL scan_v%0d: got %b want 1", k, v); end
      total++; if (ch !== exp_ch[k]) begin bad++; $display("FAIL scan_ch%0d: got %0d want %0d", k, ch, exp_ch[k]); end
      total++; if (count !== exp_cnt[k]) begin bad++; $display("FAIL scan_cnt%0d: got %0d want %0d", k, count, exp_cnt[k]); end
      if (k == 3) begin
        total++; if (fault !== 4'b1001) begin bad++; $display("FAIL scan_fault: got %b want 1001", fault); end
      end
      consume(k != 4);
    end
  endtask

  task automatic test_backpressure();
    int n, errs;
    en = 1'b1;
    wait_v(300, n);
    total++; if (ch !== 2'd1 || count !== 16'd8) begin bad++; $display("FAIL bp_first: got ch=%0d cnt=%0d want ch=1 cnt=8", ch, count); end
    errs = 0;
    repeat (500) begin
      step();
      if (v !== 1'b1 || count !== 16'd8 || ch !== 2'd1) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", errs); end
    consume(1'b1);
    wait_v(300, n);
    total++; if (ch !== 2'd2 || count !== 16'd4) begin bad++; $display("FAIL bp_next: got ch=%0d cnt=%0d want ch=2 cnt=4", ch, count); end
    consume(1'b0);
  endtask

  task automatic test_sat();
    int n;
    scan = 1'b0; sel = 2'd0; window = 16'd100;
    en4 = 1'b1;
    n = 0;
    while (v4 !== 1'b1 && n < 300) begin step(); n++; end
    total++; if (count4 !== 4'hF) begin bad++; $display("FAIL sat_count: got %h want f", count4); end
    total++; if (sat4 !== 1'b1)   begin bad++; $display("FAIL sat_flag: got %b want 1", sat4); end
    en4 = 1'b0; yumi4 = 1'b1; step(); yumi4 = 1'b0;
  endtask

  task automatic test_abort_clear();
    int hits;
    scan = 1'b0; sel = 2'd1; window = 16'd64;
    en = 1'b1;
    repeat (20) step();
    en = 1'b0;
    hits = 0;
    repeat (100) begin step(); if (v === 1'b1) hits++; end
    total++; if (hits != 0) begin bad++; $display("FAIL abort_v: got %0d valid cycles want 0", hits); end
    total++; if (fault !== 4'b1001) begin bad++; $display("FAIL abort_fault: got %b want 1001", fault); end
    lo = 16'd20; hi = 16'd30;
    en = 1'b1;
    repeat (67) step();
    clear = 1'b1; step(); clear = 1'b0;
    total++; if (v !== 1'b1) begin bad++; $display("FAIL clr_v: got %b want 1", v); end
    total++; if (fault !== 4'b0010) begin bad++; $display("FAIL clr_fault: got %b want 0010", fault); end
    consume(1'b0);
  endtask

  task automatic test_window0_reset();
    int n;
    sel = 2'd0; window = 16'd0;
    en = 1'b1;
    wait_v(50, n);
    total++; if (n != 5) begin bad++; $display("FAIL w0_lat: got %0d want 5", n); end
    consume(1'b0);
    window = 16'd16;
    en = 1'b1;
    wait_v(100, n);
    total++; if (count !== 16'd4) begin bad++; $display("FAIL rstmid_cnt: got %0d want 4", count); end
    total++; if (fault !== 4'b0011) begin bad++; $display("FAIL rstmid_fault_pre: got %b want 0011", fault); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (v !== 1'b0)      begin bad++; $display("FAIL arst_v: got %b want 0", v); end
    total++; if (fault !== 4'd0)  begin bad++; $display("FAIL arst_fault: got %b want 0000", fault); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL arst_count: got %0d want 0", count); end
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_backpressure();
    test_sat();
    test_abort_clear();
    test_window0_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
